election_report_unit: RTL

Downstream consumer of the voting-machine stage. Samples that stage's per-cycle outputs, classifies and counts rejected requests across the registration and voting phases, and captures the final winner once voting has closed. It then emits a fixed 6-byte result report over a valid/ready byte stream to the announcement/display logic.

---
 rtl/election_report_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/election_report_unit.sv
// ---------------------------------------------------------------------------
// election_report_unit
//
// Sits after the voting-machine stage. It samples that stage's per-cycle
// outputs, counts rejected requests by category over the registration and
// voting phases, captures the final winner once voting has closed, and then
// streams a fixed 6-byte result report over a valid/ready byte interface.
//
// Ports:
//   CLK                       clock, rising edge
//   RST_N                     asynchronous active-low reset
//   in_valid                  upstream sample strobe (one pulse per sample)
//   ballotBoxId               upstream ballot box (not part of the report)
//   numberOfRegisteredVoters  upstream registered-voter count (6 bit)
//   numberOfVotesWinner       upstream winner vote count (6 bit)
//   WinnerId                  upstream winner id (2 bit)
//   AlreadyRegistered,
//   VotingHasNotStarted       registration-phase reject flags
//   AlreadyVoted,
//   NotRegistered,
//   RegistrationHasEnded      voting-phase reject flags
//   out_data / out_valid      report byte stream towards the display logic
//   out_ready                 sink accepts a byte when out_valid && out_ready
//   reg_reject_cnt            saturating registration-phase reject count
//   vote_reject_cnt           saturating voting-phase reject count
//   report_done               all six report bytes accepted (sticky)
//
// Report layout: HEADER, {WinnerId, votes}, {2'b00, registered},
//                reg rejects, vote rejects, XOR of the first five bytes.
// ---------------------------------------------------------------------------
module election_report_unit #(
  parameter int unsigned REG_CYCLES  = 100,
  parameter int unsigned VOTE_CYCLES = 100,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       in_valid,
  input  logic [1:0] ballotBoxId,
  input  logic [5:0] numberOfRegisteredVoters,
  input  logic [5:0] numberOfVotesWinner,
  input  logic [1:0] WinnerId,
  input  logic       AlreadyRegistered,
  input  logic       VotingHasNotStarted,
  input  logic       AlreadyVoted,
  input  logic       NotRegistered,
  input  logic       RegistrationHasEnded,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] reg_reject_cnt,
  output logic [7:0] vote_reject_cnt,
  output logic       report_done
);

  typedef enum logic [1:0] {
    ST_COLLECT     = 2'd0,
    ST_WAIT_RESULT = 2'd1,
    ST_SEND        = 2'd2,
    ST_DONE        = 2'd3
  } state_t;

  // Phase boundaries expressed in the width of the sample counter.
  localparam logic [7:0] REG_LIM_C = 8'(REG_CYCLES);
  localparam logic [7:0] TOTAL_C   = 8'(REG_CYCLES + VOTE_CYCLES);
  localparam logic [2:0] LAST_IDX_C = 3'd5;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Longitudinal XOR check byte over the five payload bytes.
  function automatic logic [7:0] report_checksum(input logic [7:0] b1,
                                                 input logic [7:0] b2,
                                                 input logic [7:0] b3,
                                                 input logic [7:0] b4);
    return HEADER ^ b1 ^ b2 ^ b3 ^ b4;
  endfunction

  // Byte selected for a given report index.
  function automatic logic [7:0] report_byte(input logic [2:0] idx,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2,
                                             input logic [7:0] b3,
                                             input logic [7:0] b4,
                                             input logic [7:0] chk);
    logic [7:0] r;
    case (idx)
      3'd0:    r = HEADER;
      3'd1:    r = b1;
      3'd2:    r = b2;
      3'd3:    r = b3;
      3'd4:    r = b4;
      3'd5:    r = chk;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t     state_r,      state_s;
  logic [7:0] sample_cnt_r, sample_cnt_s;
  logic [7:0] reg_cnt_r,    reg_cnt_s;
  logic [7:0] vote_cnt_r,   vote_cnt_s;
  logic [2:0] idx_r,        idx_s;
  logic [7:0] rep_b1_r,     rep_b1_s;
  logic [7:0] rep_b2_r,     rep_b2_s;
  logic [7:0] rep_b3_r,     rep_b3_s;
  logic [7:0] rep_b4_r,     rep_b4_s;
  logic [7:0] rep_chk_r,    rep_chk_s;
  logic [7:0] out_data_r,   out_data_s;
  logic       out_valid_r,  out_valid_s;
  logic       done_r,       done_s;

  logic       reg_flag_s;
  logic       vote_flag_s;
  logic [7:0] cap_b1_s;
  logic [7:0] cap_b2_s;

  // The ballot box id travels with the sample but never reaches the report.
  logic unused_ok_s;
  assign unused_ok_s = ^ballotBoxId;

  assign reg_flag_s  = AlreadyRegistered | VotingHasNotStarted;
  assign vote_flag_s = AlreadyVoted | NotRegistered | RegistrationHasEnded;
  assign cap_b1_s    = {WinnerId, numberOfVotesWinner};
  assign cap_b2_s    = {2'b00, numberOfRegisteredVoters};

  // Next-state, counter, capture and stream-output logic.
  always_comb begin
    state_s      = state_r;
    sample_cnt_s = sample_cnt_r;
    reg_cnt_s    = reg_cnt_r;
    vote_cnt_s   = vote_cnt_r;
    idx_s        = idx_r;
    rep_b1_s     = rep_b1_r;
    rep_b2_s     = rep_b2_r;
    rep_b3_s     = rep_b3_r;
    rep_b4_s     = rep_b4_r;
    rep_chk_s    = rep_chk_r;
    out_data_s   = out_data_r;
    out_valid_s  = out_valid_r;
    done_s       = done_r;

    case (state_r)
      ST_COLLECT: begin
        if (in_valid) begin
          // Registration flags only count inside the registration window;
          // any sample not claimed by that category may count as a vote reject.
          if ((sample_cnt_r < REG_LIM_C) && reg_flag_s) begin
            reg_cnt_s = sat_inc8(reg_cnt_r);
          end else if (vote_flag_s) begin
            vote_cnt_s = sat_inc8(vote_cnt_r);
          end else begin
            vote_cnt_s = vote_cnt_r;
          end
          sample_cnt_s = sample_cnt_r + 8'd1;
          if (sample_cnt_s == TOTAL_C) begin
            state_s = ST_WAIT_RESULT;
          end else begin
            state_s = ST_COLLECT;
          end
        end else begin
          state_s = ST_COLLECT;
        end
      end

      ST_WAIT_RESULT: begin
        if (in_valid) begin
          // Freeze the result and the counters so the report is self-consistent.
          rep_b1_s    = cap_b1_s;
          rep_b2_s    = cap_b2_s;
          rep_b3_s    = reg_cnt_r;
          rep_b4_s    = vote_cnt_r;
          rep_chk_s   = report_checksum(cap_b1_s, cap_b2_s, reg_cnt_r, vote_cnt_r);
          idx_s       = 3'd0;
          out_data_s  = HEADER;
          out_valid_s = 1'b1;
          state_s     = ST_SEND;
        end else begin
          state_s = ST_WAIT_RESULT;
        end
      end

      ST_SEND: begin
        if (out_valid_r && out_ready) begin
          if (idx_r == LAST_IDX_C) begin
            out_valid_s = 1'b0;
            out_data_s  = 8'h00;
            done_s      = 1'b1;
            state_s     = ST_DONE;
          end else begin
            // Present the following byte on the very next cycle.
            idx_s      = idx_r + 3'd1;
            out_data_s = report_byte(idx_s, rep_b1_r, rep_b2_r, rep_b3_r,
                                     rep_b4_r, rep_chk_r);
            state_s    = ST_SEND;
          end
        end else begin
          state_s = ST_SEND;
        end
      end

      ST_DONE: begin
        out_valid_s = 1'b0;
        done_s      = 1'b1;
        state_s     = ST_DONE;
      end

      default: begin
        state_s = ST_COLLECT;
      end
    endcase
  end

  // State and datapath registers; reset aborts any report in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_COLLECT;
      sample_cnt_r <= 8'h00;
      reg_cnt_r    <= 8'h00;
      vote_cnt_r   <= 8'h00;
      idx_r        <= 3'd0;
      rep_b1_r     <= 8'h00;
      rep_b2_r     <= 8'h00;
      rep_b3_r     <= 8'h00;
      rep_b4_r     <= 8'h00;
      rep_chk_r    <= 8'h00;
      out_data_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      sample_cnt_r <= sample_cnt_s;
      reg_cnt_r    <= reg_cnt_s;
      vote_cnt_r   <= vote_cnt_s;
      idx_r        <= idx_s;
      rep_b1_r     <= rep_b1_s;
      rep_b2_r     <= rep_b2_s;
      rep_b3_r     <= rep_b3_s;
      rep_b4_r     <= rep_b4_s;
      rep_chk_r    <= rep_chk_s;
      out_data_r   <= out_data_s;
      out_valid_r  <= out_valid_s;
      done_r       <= done_s;
    end
  end

  assign out_data        = out_data_r;
  assign out_valid       = out_valid_r;
  assign reg_reject_cnt  = reg_cnt_r;
  assign vote_reject_cnt = vote_cnt_r;
  assign report_done     = done_r;

endmodule
